// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with a free-running digit scanner that feeds
// one BCD-to-7-segment decoder through a one-hot digit select and a blank flag.
module bcd_scan_counter #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        up,
  input  logic        clr,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        lz_en,
  output logic [15:0] count,
  output logic        wrap,
  output logic [3:0]  bcd,
  output logic [3:0]  dig_sel,
  output logic        blank
);

  localparam int unsigned DIGITS = 4;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned CNT_W  = DIGITS * NIB_W;
  localparam int unsigned DIV_W  = 16;
  localparam int unsigned IDX_W  = 2;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [CNT_W:0]   step_val;
  logic [CNT_W-1:0] load_clean;
  logic [DIGITS-1:0] dig_zero;

  // Ripple BCD step: returns {carry/borrow out, stepped value}.
  function automatic logic [CNT_W:0] bcd_step(input logic [CNT_W-1:0] v,
                                               input logic dir_up);
    logic [CNT_W-1:0] r;
    logic             c;
    logic [NIB_W-1:0] d;
    r = v;
    c = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      d = v[NIB_W*k +: NIB_W];
      if (c) begin
        if (dir_up) begin
          if (d == 4'd9) begin
            d = 4'd0;
          end else begin
            d = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            d = 4'd9;
          end else begin
            d = d - 4'd1;
            c = 1'b0;
          end
        end
      end
      r[NIB_W*k +: NIB_W] = d;
    end
    return {c, r};
  endfunction

  // Invalid load nibbles are replaced by zero.
  always_comb begin
    load_clean = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (load_val[NIB_W*k +: NIB_W] <= 4'd9) begin
        load_clean[NIB_W*k +: NIB_W] = load_val[NIB_W*k +: NIB_W];
      end
    end
  end

  assign step_val = bcd_step(count_q, up);

  // Counter next state, priority clr > load > en.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_clean;
    end else if (en) begin
      count_d = step_val[CNT_W-1:0];
      wrap_d  = step_val[CNT_W];
    end
  end

  // Scanner prescaler and digit index.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q >= DIV_LAST) begin
      div_d = '0;
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      div_q   <= '0;
      idx_q   <= '0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    for (int k = 0; k < DIGITS; k++) begin
      dig_zero[k] = (count_q[NIB_W*k +: NIB_W] == 4'd0);
    end
  end

  // Digit k is blanked when it and every more significant digit are zero.
  always_comb begin
    blank = 1'b0;
    if (lz_en) begin
      case (idx_q)
        2'd1:    blank = dig_zero[1] & dig_zero[2] & dig_zero[3];
        2'd2:    blank = dig_zero[2] & dig_zero[3];
        2'd3:    blank = dig_zero[3];
        default: blank = 1'b0;
      endcase
    end
  end

  assign count   = count_q;
  assign wrap    = wrap_q;
  assign dig_sel = 4'b0001 << idx_q;
  assign bcd     = count_q[NIB_W*idx_q +: NIB_W];

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter with SCAN_DIV=3: counting, wrap,
// load sanitising, priority, scan sequence, leading-zero blanking and reset.
module tb_bcd_scan_counter;

  localparam int unsigned SCAN_DIV = 3;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        up;
  logic        clr;
  logic        load;
  logic [15:0] load_val;
  logic        lz_en;
  logic [15:0] count;
  logic        wrap;
  logic [3:0]  bcd;
  logic [3:0]  dig_sel;
  logic        blank;

  int checks;
  int failures;
  int cyc;

  bcd_scan_counter #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .lz_en    (lz_en),
    .count    (count),
    .wrap     (wrap),
    .bcd      (bcd),
    .dig_sel  (dig_sel),
    .blank    (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Expected scan state derived from cycles since reset release.
  task automatic check_scan(input string tag, input logic [15:0] cnt_exp, input logic [3:0] bmask);
    int unsigned ix;
    logic [3:0]  sel_e;
    logic [15:0] sh;
    ix    = (cyc / SCAN_DIV) % 4;
    sel_e = 4'(1 << ix);
    sh    = cnt_exp >> (4 * ix);
    check_eq({tag, "_sel"}, 16'(dig_sel), 16'(sel_e));
    check_eq({tag, "_bcd"}, 16'(bcd), 16'(sh[3:0]));
    check_eq({tag, "_blank"}, 16'(blank), 16'(bmask[ix]));
  endtask

  task automatic do_load(input logic [15:0] v);
    load     = 1'b1;
    load_val = v;
    step();
    load     = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    up       = 1'b1;
    clr      = 1'b0;
    load     = 1'b0;
    load_val = 16'h0000;
    lz_en    = 1'b0;

    #3;
    check_eq("rst_count", count, 16'h0000);
    check_eq("rst_wrap", 16'(wrap), 16'h0);
    check_eq("rst_sel", 16'(dig_sel), 16'h1);
    check_eq("rst_bcd", 16'(bcd), 16'h0);
    check_eq("rst_blank", 16'(blank), 16'h0);
    release_reset();

    // Ten increments from 0000
    en = 1'b1;
    up = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("inc_wrap", 16'(wrap), 16'h0);
    end
    en = 1'b0;
    check_eq("inc10", count, 16'h0010);

    do_load(16'h0999);
    check_eq("load0999", count, 16'h0999);
    en = 1'b1;
    step();
    en = 1'b0;
    check_eq("carry1000", count, 16'h1000);
    check_eq("carry_wrap", 16'(wrap), 16'h0);

    // Wrap both directions
    do_load(16'h9999);
    en = 1'b1;
    up = 1'b1;
    step();
    check_eq("wrap_up_cnt", count, 16'h0000);
    check_eq("wrap_up", 16'(wrap), 16'h1);
    up = 1'b0;
    step();
    check_eq("wrap_dn_cnt", count, 16'h9999);
    check_eq("wrap_dn", 16'(wrap), 16'h1);
    en = 1'b0;
    step();
    check_eq("hold_cnt", count, 16'h9999);
    check_eq("hold_wrap", 16'(wrap), 16'h0);

    do_load(16'h1000);
    en = 1'b1;
    up = 1'b0;
    step();
    en = 1'b0;
    check_eq("borrow0999", count, 16'h0999);
    check_eq("borrow_wrap", 16'(wrap), 16'h0);

    // Load wins over en
    en = 1'b1;
    up = 1'b1;
    do_load(16'h0123);
    en = 1'b0;
    check_eq("load_over_en", count, 16'h0123);

    do_load(16'h1A9F);
    check_eq("load_sanitize", count, 16'h1090);

    clr      = 1'b1;
    load     = 1'b1;
    en       = 1'b1;
    load_val = 16'h5555;
    step();
    clr  = 1'b0;
    load = 1'b0;
    en   = 1'b0;
    check_eq("clr_prio", count, 16'h0000);
    check_eq("clr_wrap", 16'(wrap), 16'h0);

    // Scan sequence from a fresh reset
    rst_n = 1'b0;
    release_reset();
    check_scan("scan0", 16'h0000, 4'b0000);
    do_load(16'h4321);
    check_scan("scan", 16'h4321, 4'b0000);
    for (int i = 0; i < 23; i++) begin
      step();
      check_scan("scan", 16'h4321, 4'b0000);
    end

    // Leading-zero blanking
    lz_en = 1'b1;
    do_load(16'h0045);
    for (int i = 0; i < 12; i++) begin
      check_scan("lz45", 16'h0045, 4'b1100);
      step();
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check_scan("lz00", 16'h0000, 4'b1110);
      step();
    end
    lz_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check_scan("nolz", 16'h0000, 4'b0000);
      step();
    end

    // Reset mid-frame
    lz_en = 1'b1;
    do_load(16'h5678);
    for (int i = 0; i < 4; i++) step();
    check_eq("pre_rst_cnt", count, 16'h5678);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_count", count, 16'h0000);
    check_eq("mid_rst_wrap", 16'(wrap), 16'h0);
    check_eq("mid_rst_sel", 16'(dig_sel), 16'h1);
    check_eq("mid_rst_bcd", 16'(bcd), 16'h0);
    check_eq("mid_rst_blank", 16'(blank), 16'h0);
    release_reset();
    check_eq("rst_hold_sel", 16'(dig_sel), 16'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      check_scan("post_rst", 16'h0000, 4'b1110);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_scan_counter.md
# bcd_scan_counter

Four-digit BCD up/down counter with built-in time-multiplexed digit scanner. Sits directly upstream of the single-digit BCD-to-7-segment decoder. On each scan slot it presents one BCD nibble (bit 3 = MSB, driving the decoder's A input) together with a one-hot digit select and a blank flag, so one decoder can drive a 4-digit common display.

## Interface
Parameters:
- SCAN_DIV, default 1000: clock cycles each digit is held active. Legal range 1..65535.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- en, in, 1: count enable; one step per clk edge while high.
- up, in, 1: direction; 1 = increment, 0 = decrement.
- clr, in, 1: synchronous clear to 0000.
- load, in, 1: synchronous load of load_val.
- load_val, in, 16: four BCD digits; [3:0] = units, [15:12] = thousands.
- lz_en, in, 1: leading-zero suppression enable.
- count, out, 16: current BCD count, same packing as load_val.
- wrap, out, 1: one-cycle pulse on 9999→0000 (up) or 0000→9999 (down).
- bcd, out, 4: BCD nibble of the currently selected digit, bit 3 = MSB.
- dig_sel, out, 4: one-hot active-high digit select; bit 0 = units.
- blank, out, 1: high when the selected digit must be blanked.

## Operation
- Counter priority per edge: clr > load > en. The priority applies when several are high together.
- clr: count ← 0000. wrap ← 0.
- load: each nibble of load_val > 9 is loaded as 0. Valid nibbles are loaded unchanged. wrap ← 0.
- en with up=1: ripple BCD increment. A digit at 9 goes to 0 and carries into the next digit. 9999 → 0000 with wrap=1.
- en with up=0: ripple BCD decrement. A digit at 0 goes to 9 and borrows from the next digit. 0000 → 9999 with wrap=1.
- With no action, count holds and wrap=0.
- Scanner:
  - A prescaler counts 0..SCAN_DIV-1.
  - On its terminal count it returns to 0 and the digit index advances 0→1→2→3→0.
  - Scanning is free-running and independent of en, clr and load.
- dig_sel = one-hot of the index (index 0 → 0001, 3 → 1000).
- bcd = count nibble of the index. This is a combinational mux from registered count and index, so a count change appears on bcd in the same cycle count changes.
- blank:
  - Always 0 when lz_en=0, and always 0 for index 0 (the units digit is never blanked).
  - For index k>0 with lz_en=1: blank=1 iff count digits k..3 are all zero.

## Timing
- Reset values (asynchronous, immediate on rst_n low): count=0000, wrap=0, prescaler=0, index=0, dig_sel=0001, bcd=0000, blank=0.
- Count latency is one cycle: count updates on the first rising edge where en/clr/load is sampled high.
- wrap is registered. It is high during exactly the cycle in which count shows the wrapped value, and low in the next cycle unless a further wrap occurs.
- Sustained en=1 counts every cycle. A wrap on consecutive cycles is impossible except with up toggling between 0000 and 9999. In that case wrap stays high every cycle, which is legal.
- After reset release, digit 0 is selected for exactly SCAN_DIV cycles, then each subsequent digit for SCAN_DIV cycles each. The full frame is 4·SCAN_DIV cycles.
- SCAN_DIV=1: index advances every edge.
- dig_sel, bcd and blank change together with no skew cycle. No two dig_sel bits are ever high at once.
- Reset mid-count or mid-scan: all state returns to the reset values at once. Scanning restarts at digit 0 with the full SCAN_DIV hold.

## Test plan
- Reset then en=1, up=1 for 10 cycles from 0000 → count=0x0010. Load 0x0999, one en → 0x1000. wrap stays 0 throughout.
- Load 0x9999, en=1, up=1 for one cycle → count=0x0000 and wrap=1 for one cycle. Then up=0 for one cycle → 0x9999 with wrap=1.
- Load 0x1A9F → count=0x1090. Assert clr, load and en together → count=0x0000.
- SCAN_DIV=3, count=0x4321: dig_sel sequence 0001,0010,0100,1000 each held 3 cycles, with bcd=1,2,3,4 in step. The sequence repeats with a 12-cycle period.
- lz_en=1, count=0x0045: blank=1 on digits 3 and 2 and 0 on digits 1 and 0. count=0x0000 → only digit 0 unblanked. lz_en=0 → blank always 0.
- Assert rst_n low mid-frame while count=0x5678 → all outputs at reset values immediately. After release, digit 0 is held a full SCAN_DIV cycles.
